// File: rtl/keypad_pkg.sv
// Shared widths, FSM state type and one-hot key to BCD encoder for the keypad digit loader.
package keypad_pkg;
    localparam int KEY_W   = 10;
    localparam int DIGIT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_DB,
        LOAD,
        HELD,
        REL_DB
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] digit;
        logic               onehot_ok;
    } digit_enc_t;

    // digit is the index of the highest set key; onehot_ok only when exactly one key is set
    function automatic digit_enc_t onehot_to_bcd(input logic [KEY_W-1:0] keys);
        digit_enc_t  enc;
        int unsigned hits;
        enc  = '0;
        hits = 0;
        for (int i = 0; i < KEY_W; i++) begin
            if (keys[i]) begin
                enc.digit = DIGIT_W'(i);
                hits++;
            end
        end
        enc.onehot_ok = (hits == 1);
        return enc;
    endfunction
endpackage

// File: rtl/keypad_digit_loader_debouncer.sv
// Two-flop synchroniser on the raw key lines plus a stability counter that
// restarts on every change of the synchronised vector.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             clearn,
    input  logic [KEY_W-1:0] keypad,
    output logic [KEY_W-1:0] keys_sync,
    output logic             stable
);
    localparam logic [7:0] CNT_TC = 8'(DEBOUNCE_CYCLES);

    logic [KEY_W-1:0] sync_1;
    logic [7:0]       stable_cnt;

    always_ff @(posedge clock or posedge clearn) begin
        if (clearn) begin
            sync_1     <= '0;
            keys_sync  <= '0;
            stable_cnt <= '0;
        end else begin
            sync_1    <= keypad;
            keys_sync <= sync_1;
            if (sync_1 != keys_sync) begin
                stable_cnt <= '0;
            end else if (stable_cnt != CNT_TC) begin
                stable_cnt <= stable_cnt + 8'd1;
            end
        end
    end

    // A change already in the first flop vetoes stability, so the reset-cleared
    // pipeline never looks like a settled all-zero vector while a key is held.
    assign stable = (stable_cnt == CNT_TC) && (sync_1 == keys_sync);
endmodule

// File: rtl/keypad_digit_loader.sv
// Debounced keypad to BCD digit loader with a one-cycle active-low load strobe.
// Build option KEYPAD_LEADING_ZERO_SKIP_EN: key "0" pressed with no digits loaded is ignored.
module keypad_digit_loader
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_DIGITS      = 3
) (
    input  logic               clock,
    input  logic               clearn,
    input  logic [KEY_W-1:0]   keypad,
    input  logic               accept,
    input  logic               clear_digits,
    output logic [DIGIT_W-1:0] data,
    output logic               loadn,
    output logic [1:0]         digit_count,
    output logic               full,
    output logic               key_error
);
    localparam logic [1:0] COUNT_MAX = 2'(MAX_DIGITS);

    logic [KEY_W-1:0] keys_sync;
    logic             stable;
    logic             armed;
    logic             skip_zero;
    state_t           state;
    digit_enc_t       enc;

    key_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clock    (clock),
        .clearn   (clearn),
        .keypad   (keypad),
        .keys_sync(keys_sync),
        .stable   (stable)
    );

    assign enc  = onehot_to_bcd(keys_sync);
    assign full = (digit_count == COUNT_MAX);

`ifdef KEYPAD_LEADING_ZERO_SKIP_EN
    assign skip_zero = (enc.digit == '0) && (digit_count == 2'd0);
`else
    assign skip_zero = 1'b0;
`endif

    always_ff @(posedge clock or posedge clearn) begin
        if (clearn) begin
            state       <= IDLE;
            armed       <= 1'b0;
            data        <= '0;
            loadn       <= 1'b1;
            key_error   <= 1'b0;
            digit_count <= 2'd0;
        end else begin
            loadn     <= 1'b1;
            key_error <= 1'b0;

            if (clear_digits) begin
                digit_count <= 2'd0;
            end else if (state == LOAD && !full) begin
                digit_count <= digit_count + 2'd1;
            end

            case (state)
                // Until a settled all-zero vector is seen, a key held across reset is ignored.
                IDLE: begin
                    if (!armed) begin
                        if (keys_sync == '0 && stable) armed <= 1'b1;
                    end else if (keys_sync != '0) begin
                        state <= PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (keys_sync == '0) begin
                        state <= IDLE;
                    end else if (stable) begin
                        if (!enc.onehot_ok) begin
                            key_error <= 1'b1;
                            state     <= HELD;
                        end else if (accept && !full && !skip_zero) begin
                            data  <= enc.digit;
                            loadn <= 1'b0;
                            state <= LOAD;
                        end else begin
                            state <= HELD;
                        end
                    end
                end
                LOAD: state <= HELD;
                HELD: begin
                    if (keys_sync == '0) state <= REL_DB;
                end
                REL_DB: begin
                    if (keys_sync != '0) begin
                        state <= HELD;
                    end else if (stable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_keypad_digit_loader.sv
// Scoreboard bench for keypad_digit_loader: directed cases then randomized presses.
module tb_keypad_digit_loader;
    localparam int DEB  = 4;
    localparam int MAXD = 3;

    logic       clock = 1'b0;
    logic       clearn = 1'b1;
    logic [9:0] keypad = '0;
    logic       accept = 1'b1;
    logic       clear_digits = 1'b0;
    logic [3:0] data;
    logic       loadn;
    logic [1:0] digit_count;
    logic       full;
    logic       key_error;

    always #5 clock = ~clock;

    keypad_digit_loader #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_DIGITS     (MAXD)
    ) dut (
        .clock       (clock),
        .clearn      (clearn),
        .keypad      (keypad),
        .accept      (accept),
        .clear_digits(clear_digits),
        .data        (data),
        .loadn       (loadn),
        .digit_count (digit_count),
        .full        (full),
        .key_error   (key_error)
    );

    typedef struct {
        bit         is_err;
        logic [3:0] data;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_ev;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_count = 0;
    logic [3:0] m_data = '0;
    bit         prev_low = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every strobe or error pulse must match the next expected event.
    always @(negedge clock) begin
        if (!clearn && (loadn === 1'b0 || key_error === 1'b1)) begin
            if (loadn === 1'b0) check("strobe_width", 32'(prev_low), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_event: loadn=%0b key_error=%0b data=%0d, expected no event",
                         loadn, key_error, data);
            end else begin
                mon_ev = exp_q.pop_front();
                check("event_is_error", 32'(key_error), 32'(mon_ev.is_err));
                check("event_data", 32'(data), 32'(mon_ev.data));
            end
        end
        prev_low = (loadn === 1'b0);
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Reference: the final steady vector of a press decides its single outcome.
    task automatic model_press(input logic [9:0] keys);
        int  ones;
        int  d;
        bit  skip;
        ev_t e;
        ones = $countones(keys);
        d    = 0;
        skip = 1'b0;
        for (int i = 0; i < 10; i++) if (keys[i]) d = i;
        if (ones == 1) begin
`ifdef KEYPAD_LEADING_ZERO_SKIP_EN
            skip = (d == 0) && (m_count == 0);
`endif
            if (!skip && accept && m_count < MAXD) begin
                m_data = 4'(d);
                m_count++;
                e.is_err = 1'b0;
                e.data   = m_data;
                exp_q.push_back(e);
            end
        end else if (ones > 1) begin
            e.is_err = 1'b1;
            e.data   = m_data;
            exp_q.push_back(e);
        end
    endtask

    task automatic press(input logic [9:0] keys, input bit bounce);
        if (bounce) begin
            repeat ($urandom_range(1, 3)) begin
                keypad = keys;
                cycles($urandom_range(1, DEB - 1));
                keypad = '0;
                cycles($urandom_range(1, DEB - 1));
            end
        end
        keypad = keys;
        model_press(keys);
        cycles(DEB + 6 + $urandom_range(0, 6));
        if (bounce) begin
            repeat ($urandom_range(1, 3)) begin
                keypad = '0;
                cycles($urandom_range(1, DEB - 1));
                keypad = keys;
                cycles($urandom_range(1, DEB - 1));
            end
        end
        keypad = '0;
        cycles(DEB + 8);
        check("digit_count", 32'(digit_count), 32'(m_count));
        check("full", 32'(full), 32'(m_count == MAXD));
    endtask

    task automatic clear_pulse();
        clear_digits = 1'b1;
        cycles(1);
        clear_digits = 1'b0;
        m_count = 0;
    endtask

    task automatic check_reset();
        check("reset_data", 32'(data), 0);
        check("reset_loadn", 32'(loadn), 1);
        check("reset_count", 32'(digit_count), 0);
        check("reset_full", 32'(full), 0);
        check("reset_key_error", 32'(key_error), 0);
    endtask

    task automatic collide();
        bit got;
        got = 1'b0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clock);
            if (loadn === 1'b0) got = 1'b1;
        end
        check("collision_strobe_seen", 32'(got), 1);
        if (got) begin
            clear_digits = 1'b1;
            @(posedge clock);
            #1;
            clear_digits = 1'b0;
            m_count = 0;
            check("clear_wins_over_load", 32'(digit_count), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  found;
        logic [9:0] k;
        int  d1;
        int  d2;

        repeat (3) @(posedge clock);
        #1;
        check_reset();
        clearn = 1'b0;
        cycles(DEB + 4);

        // Latency: key 7 first sampled at edge t0
        keypad = 10'b1 << 7;
        model_press(keypad);
        @(posedge clock);
        lat = 0;
        found = 1'b0;
        for (int n = 1; n <= 12 && !found; n++) begin
            @(posedge clock);
            #1;
            if (loadn === 1'b0) begin
                found = 1'b1;
                lat = n;
            end
        end
        check("load_latency", 32'(lat), DEB + 2);
        cycles(12);
        keypad = '0;
        cycles(DEB + 8);
        check("data_after_7", 32'(data), 32'(m_data));
        check("count_after_7", 32'(digit_count), 32'(m_count));

        press(10'b1 << 3, 1'b1);
        press((10'b1 << 2) | (10'b1 << 5), 1'b0);
        check("data_after_multi", 32'(data), 32'(m_data));

        clear_pulse();
        for (int d = 1; d <= 4; d++) press(10'b1 << d, 1'b0);

        accept = 1'b0;
        press(10'b1 << 9, 1'b0);
        accept = 1'b1;

        clear_pulse();
        press(10'b1 << 1, 1'b0);
        fork
            press(10'b1 << 6, 1'b0);
            collide();
        join

        // Reset while key 4 is held; the held key must not load after reset release
        keypad = 10'b1 << 4;
        model_press(keypad);
        cycles(DEB + 8);
        clearn = 1'b1;
        cycles(2);
        check_reset();
        m_count = 0;
        m_data  = '0;
        clearn = 1'b0;
        cycles(30);
        check("no_load_after_reset", 32'(digit_count), 0);
        keypad = '0;
        cycles(DEB + 8);
        press(10'b1 << 4, 1'b0);

        clear_pulse();
        press(10'b1 << 0, 1'b0);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) clear_pulse();
            accept = ($urandom_range(0, 3) != 0);
            d1 = $urandom_range(0, 9);
            if ($urandom_range(0, 4) == 0 && m_count < MAXD) begin
                d2 = (d1 + $urandom_range(1, 9)) % 10;
                k = (10'b1 << d1) | (10'b1 << d2);
            end else begin
                k = 10'b1 << d1;
            end
            press(k, 1'($urandom_range(0, 1)));
        end

        check("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_digit_loader.md
Name: keypad_digit_loader

Overview:
Producer side of the countdown timer's digit-load interface. Takes the 10 raw decimal key lines of the front panel and synchronises and debounces them. Each valid key press becomes one BCD digit on data, with a single-cycle active-low loadn strobe. The timer shifts that digit in, ones to tens to minutes, so three presses enter M:SS.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive equal synchronised samples required before a key state is accepted (min 1, max 255).
MAX_DIGITS, 3, number of digits accepted before further presses are ignored (min 1, max 3).

Ports:
clock  input  1  system clock, all state on rising edge
clearn  input  1  reset, asynchronous, active-high (name retained from codebase)
keypad  input  10  raw key lines, bit i = key "i", active-high, asynchronous to clock
accept  input  1  1 = timer stopped and entry allowed; 0 = presses debounced but discarded
clear_digits  input  1  synchronous; resets digit_count to 0 (issued alongside timer clear)
data  output  4  BCD digit to the timer data input; holds last loaded value
loadn  output  1  load strobe, active-low, low for exactly one clock per accepted digit
digit_count  output  2  digits loaded since reset/clear_digits, saturates at MAX_DIGITS
full  output  1  digit_count == MAX_DIGITS
key_error  output  1  one-cycle pulse: stable multi-key press detected

Behaviour:
- Reset (clearn=1, async): data=0, loadn=1, digit_count=0, full=0, key_error=0, FSM=IDLE, synchroniser and debounce counter cleared. Reset mid-press: on release of clearn the FSM sits in IDLE and must see the keys go stable-zero first, so a key still held at reset release is not loaded.
- Synchroniser: 2 flops on keypad. Debouncer: a counter reloads on any change of the synchronised vector. The vector is "stable" once it has been unchanged for DEBOUNCE_CYCLES edges.
- FSM states: IDLE, PRESS_DB, LOAD, HELD, REL_DB.
  - IDLE: wait for the synchronised vector to be non-zero, then go to PRESS_DB.
  - PRESS_DB: vector returns to zero before stable, go to IDLE (glitch, no action). Stable and exactly one-hot, go to LOAD if accept=1 and full=0, otherwise go to HELD. Stable multi-hot, pulse key_error and go to HELD.
  - LOAD: loadn=0 for this one cycle. data is updated to the encoded digit on entry to LOAD and is held afterwards. digit_count increments at the end of LOAD. Go to HELD.
  - HELD: stable zero required; on any zero vector go to REL_DB.
  - REL_DB: non-zero before stable, go back to HELD. Stable zero, go to IDLE.
- Latency: key held steady from edge t0 gives loadn low during the cycle after edge t0+2+DEBOUNCE_CYCLES, for exactly one cycle.
- accept and full are evaluated only at the PRESS_DB exit decision. A later change has no effect on that press.
- A key change while in HELD (key rolled to another key without release) is not loaded. Release to all-zero is mandatory between digits.
- clear_digits in the same cycle as LOAD: clear wins, so digit_count=0 at the next edge; the loadn strobe is still issued.
- digit_count never wraps. When full, presses are debounced and go to HELD silently, without key_error.
- loadn is registered and glitch-free. No combinational path from keypad to any output.

Optional Feature:
Macro KEYPAD_LEADING_ZERO_SKIP_EN.
- Defined: a stable key "0" with digit_count==0 goes to HELD without a LOAD. No strobe, no count change, so leading zeros never consume a digit slot.
- Undefined: key "0" is treated like every other digit.

Decomposition:
- Package keypad_pkg holds:
  - KEY_W=10 and DIGIT_W=4;
  - the FSM state enum (IDLE, PRESS_DB, LOAD, HELD, REL_DB);
  - a one-hot-to-BCD encode function returning digit plus a onehot_ok flag.
- One natural sub-module, key_debouncer: 2-flop synchroniser plus stability counter, parameterised by DEBOUNCE_CYCLES. Outputs are the synchronised vector and a stable flag.
- The FSM and digit counter stay in keypad_digit_loader.

Test Plan:
- accept=1, press key 7 steadily for 20 cycles then release, DEBOUNCE_CYCLES=4 -> data=7; loadn low exactly one cycle, 6 cycles after first sample; digit_count=1.
- Key 3 bouncing 1-0-1-0 at 1-cycle intervals, then steady -> exactly one loadn strobe; data=3.
- Keys 2 and 5 pressed together and held -> key_error one-cycle pulse; no loadn; data unchanged.
- Sequence 1,2,3,4 with releases, MAX_DIGITS=3 -> three strobes with data 1,2,3; full=1 after the third; fourth press gives no strobe and digit_count stays 3.
- accept=0, press 9; then clear_digits during a LOAD cycle -> no strobe for the accept=0 press; in the collision case the strobe is issued and digit_count=0 at the next edge.
- Assert clearn while key 4 is held, release clearn with key still held -> all outputs at reset values; no strobe until the key is released and re-pressed. With KEYPAD_LEADING_ZERO_SKIP_EN defined, first press of 0 gives no strobe and digit_count=0.
